// File: rtl/winograd_acc.sv
// winograd_acc: sums the two signed Winograd lane results across a channel
// group terminated by a last flag, and holds each completed group's sums,
// beat count and sticky overflow in a one-entry valid/ready output register.
module winograd_acc #(
    parameter int unsigned IN_SIZE  = 21,
    parameter int unsigned ACC_SIZE = 32,
    parameter int unsigned CNT_SIZE = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    input  logic                       in_last_i,
    input  logic signed [IN_SIZE-1:0]  in_i [0:1],
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic signed [ACC_SIZE-1:0] out_o [0:1],
    output logic [CNT_SIZE-1:0]        out_cnt_o,
    output logic                       out_ovf_o
);

    // EMPTY: no beat of the current group accepted yet, so acc/cnt/ovf are masked.
    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_BUSY  = 1'b1
    } state_e;

    localparam logic [CNT_SIZE-1:0] CNT_ONE = CNT_SIZE'(1'b1);
    localparam logic [CNT_SIZE-1:0] CNT_MAX = {CNT_SIZE{1'b1}};

    // Sign-extend an input sample to accumulator width.
    function automatic logic [ACC_SIZE-1:0] sext_in(input logic [IN_SIZE-1:0] v);
        logic [ACC_SIZE-1:0] r;
        r = {ACC_SIZE{v[IN_SIZE-1]}};
        r[IN_SIZE-1:0] = v;
        return r;
    endfunction

    // Two's-complement add overflow: equal operand signs, result sign differs.
    function automatic logic add_ovf(input logic [ACC_SIZE-1:0] a,
                                     input logic [ACC_SIZE-1:0] b,
                                     input logic [ACC_SIZE-1:0] s);
        return (a[ACC_SIZE-1] == b[ACC_SIZE-1]) && (s[ACC_SIZE-1] != a[ACC_SIZE-1]);
    endfunction

    // Saturating increment of the beat counter.
    function automatic logic [CNT_SIZE-1:0] sat_inc(input logic [CNT_SIZE-1:0] c);
        logic [CNT_SIZE-1:0] r;
        if (c == CNT_MAX) begin
            r = CNT_MAX;
        end else begin
            r = c + CNT_ONE;
        end
        return r;
    endfunction

    // Architectural state
    state_e                     state_q;
    logic [ACC_SIZE-1:0]        acc_q [0:1];
    logic [CNT_SIZE-1:0]        cnt_q;
    logic                       ovf_q;
    logic                       out_valid_q;
    logic [ACC_SIZE-1:0]        out_q [0:1];
    logic [CNT_SIZE-1:0]        out_cnt_q;
    logic                       out_ovf_q;

    // Next-state datapath values
    logic                       in_ready_s;
    logic                       accept_s;
    logic                       pop_s;
    logic                       empty_s;
    logic [ACC_SIZE-1:0]        base_s   [0:1];
    logic [ACC_SIZE-1:0]        addend_s [0:1];
    logic [ACC_SIZE-1:0]        sum_d    [0:1];
    logic [1:0]                 lane_ovf_s;
    logic [CNT_SIZE-1:0]        cnt_base_s;
    logic [CNT_SIZE-1:0]        cnt_d;
    logic                       ovf_d;

    // Handshake decode: ready depends only on the output register and out_ready_i.
    always_comb begin
        in_ready_s = (!out_valid_q) | out_ready_i;
        accept_s   = in_valid_i & in_ready_s;
        pop_s      = out_valid_q & out_ready_i;
        empty_s    = (state_q == ST_EMPTY);
    end

    // Per-lane masked accumulate with overflow detection.
    always_comb begin
        for (int k = 0; k < 2; k++) begin
            if (empty_s) begin
                base_s[k] = {ACC_SIZE{1'b0}};
            end else begin
                base_s[k] = acc_q[k];
            end
            addend_s[k]   = sext_in(in_i[k]);
            sum_d[k]      = base_s[k] + addend_s[k];
            lane_ovf_s[k] = add_ovf(base_s[k], addend_s[k], sum_d[k]);
        end
    end

    // Beat counter and sticky overflow for the group including this beat.
    always_comb begin
        if (empty_s) begin
            cnt_base_s = {CNT_SIZE{1'b0}};
            ovf_d      = |lane_ovf_s;
        end else begin
            cnt_base_s = cnt_q;
            ovf_d      = ovf_q | (|lane_ovf_s);
        end
        cnt_d = sat_inc(cnt_base_s);
    end

    // Group FSM, accumulators and the one-entry output register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_EMPTY;
            acc_q[0]    <= {ACC_SIZE{1'b0}};
            acc_q[1]    <= {ACC_SIZE{1'b0}};
            cnt_q       <= {CNT_SIZE{1'b0}};
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_q[0]    <= {ACC_SIZE{1'b0}};
            out_q[1]    <= {ACC_SIZE{1'b0}};
            out_cnt_q   <= {CNT_SIZE{1'b0}};
            out_ovf_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept_s && !in_last_i) begin
                        state_q <= ST_BUSY;
                    end else begin
                        state_q <= ST_EMPTY;
                    end
                end
                ST_BUSY: begin
                    if (accept_s && in_last_i) begin
                        state_q <= ST_EMPTY;
                    end else begin
                        state_q <= ST_BUSY;
                    end
                end
                default: begin
                    state_q <= ST_EMPTY;
                end
            endcase

            if (accept_s && !in_last_i) begin
                // Mid-group beat: fold into the running sums.
                for (int k = 0; k < 2; k++) begin
                    acc_q[k] <= sum_d[k];
                end
                cnt_q <= cnt_d;
                ovf_q <= ovf_d;
            end else begin
                cnt_q <= cnt_q;
                ovf_q <= ovf_q;
            end

            if (accept_s && in_last_i) begin
                // Group complete: load result; a simultaneous pop leaves valid high.
                for (int k = 0; k < 2; k++) begin
                    out_q[k] <= sum_d[k];
                end
                out_cnt_q   <= cnt_d;
                out_ovf_q   <= ovf_d;
                out_valid_q <= 1'b1;
            end else if (pop_s) begin
                out_valid_q <= 1'b0;
            end else begin
                out_valid_q <= out_valid_q;
            end
        end
    end

    assign in_ready_o  = in_ready_s;
    assign out_valid_o = out_valid_q;
    assign out_o[0]    = out_q[0];
    assign out_o[1]    = out_q[1];
    assign out_cnt_o   = out_cnt_q;
    assign out_ovf_o   = out_ovf_q;

endmodule

// File: tb/tb_winograd_acc.sv
// tb_winograd_acc: directed stimulus for two instances (ACC_SIZE 32 and 22)
// sharing one input stream, checked every cycle against an integer model.
module tb_winograd_acc;

    logic                clk_s = 1'b0;
    logic                rst_n_s = 1'b0;
    logic                in_valid_s = 1'b0;
    logic                in_last_s = 1'b0;
    logic signed [20:0]  in_s [0:1];
    logic                out_ready_s = 1'b0;

    logic                rdy32, val32, ovf32;
    logic signed [31:0]  out32 [0:1];
    logic [15:0]         cnt32;
    logic                rdy22, val22, ovf22;
    logic signed [21:0]  out22 [0:1];
    logic [15:0]         cnt22;

    int checks = 0;
    int errors = 0;
    bit run = 1'b0;

    // Model state per instance (0: 32-bit acc, 1: 22-bit acc)
    longint m_out [0:1][0:1];
    longint m_acc [0:1][0:1];
    longint m_cnt [0:1];
    longint m_cnt_acc [0:1];
    bit     m_ovf [0:1];
    bit     m_ovf_acc [0:1];
    bit     m_valid [0:1];
    bit     m_busy [0:1];

    winograd_acc #(.IN_SIZE(21), .ACC_SIZE(32), .CNT_SIZE(16)) dut (
        .clk_i(clk_s), .rst_ni(rst_n_s), .in_valid_i(in_valid_s), .in_ready_o(rdy32),
        .in_last_i(in_last_s), .in_i(in_s), .out_valid_o(val32), .out_ready_i(out_ready_s),
        .out_o(out32), .out_cnt_o(cnt32), .out_ovf_o(ovf32));

    winograd_acc #(.IN_SIZE(21), .ACC_SIZE(22), .CNT_SIZE(16)) dut22 (
        .clk_i(clk_s), .rst_ni(rst_n_s), .in_valid_i(in_valid_s), .in_ready_o(rdy22),
        .in_last_i(in_last_s), .in_i(in_s), .out_valid_o(val22), .out_ready_i(out_ready_s),
        .out_o(out22), .out_cnt_o(cnt22), .out_ovf_o(ovf22));

    always #5 clk_s = ~clk_s;

    function automatic int width_of(input int i);
        return (i == 0) ? 32 : 22;
    endfunction

    // Reduce a true integer to the signed range of a w-bit register.
    function automatic longint wrap(input longint v, input int w);
        longint m;
        longint r;
        m = longint'(1) << w;
        r = v % m;
        if (r < 0) r = r + m;
        if (r >= m / 2) r = r - m;
        return r;
    endfunction

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_out[i][0] = 0; m_out[i][1] = 0; m_acc[i][0] = 0; m_acc[i][1] = 0;
            m_cnt[i] = 0; m_cnt_acc[i] = 0; m_ovf[i] = 1'b0; m_ovf_acc[i] = 1'b0;
            m_valid[i] = 1'b0; m_busy[i] = 1'b0;
        end
    endtask

    // Apply one clock of stimulus and advance the model by the group rules.
    task automatic cycle(input bit v, input bit last, input int a, input int b, input bit rdy);
        longint x [0:1];
        longint s [0:1];
        longint t, lo, hi, ncnt;
        bit     take, lane_ovf;
        int     w;
        @(negedge clk_s);
        #1;
        in_valid_s  = v;
        in_last_s   = last;
        in_s[0]     = 21'(a);
        in_s[1]     = 21'(b);
        out_ready_s = rdy;
        x[0] = a;
        x[1] = b;
        @(posedge clk_s);
        for (int i = 0; i < 2; i++) begin
            w  = width_of(i);
            hi = (longint'(1) << (w - 1)) - 1;
            lo = -(longint'(1) << (w - 1));
            take = v && (!m_valid[i] || rdy);
            if (m_valid[i] && rdy) m_valid[i] = 1'b0;
            if (take) begin
                lane_ovf = 1'b0;
                for (int k = 0; k < 2; k++) begin
                    t = (m_busy[i] ? m_acc[i][k] : 0) + x[k];
                    if (t > hi || t < lo) lane_ovf = 1'b1;
                    s[k] = wrap(t, w);
                end
                ncnt = (m_busy[i] ? m_cnt_acc[i] : 0) + 1;
                if (ncnt > 65535) ncnt = 65535;
                lane_ovf = lane_ovf | (m_busy[i] ? m_ovf_acc[i] : 1'b0);
                if (last) begin
                    m_out[i][0] = s[0]; m_out[i][1] = s[1];
                    m_cnt[i] = ncnt; m_ovf[i] = lane_ovf;
                    m_valid[i] = 1'b1; m_busy[i] = 1'b0;
                end else begin
                    m_acc[i][0] = s[0]; m_acc[i][1] = s[1];
                    m_cnt_acc[i] = ncnt; m_ovf_acc[i] = lane_ovf;
                    m_busy[i] = 1'b1;
                end
            end
        end
        #2;
    endtask

    task automatic do_reset();
        @(negedge clk_s);
        #1;
        rst_n_s    = 1'b0;
        in_valid_s = 1'b0;
        model_reset();
        #1;
        chk("rst_valid", val32, 0);
        chk("rst_out0", out32[0], 0);
        chk("rst_out1", out32[1], 0);
        chk("rst_cnt", cnt32, 0);
        chk("rst_ovf", ovf32, 0);
        chk("rst_ready", rdy32, 1);
        chk("rst_valid22", val22, 0);
        repeat (2) @(posedge clk_s);
        @(negedge clk_s);
        #1;
        rst_n_s = 1'b1;
    endtask

    // Every-cycle comparison of both instances against the model.
    always @(negedge clk_s) begin
        if (run) begin
            chk("ready32", rdy32, (!m_valid[0] || out_ready_s) ? 1 : 0);
            chk("valid32", val32, m_valid[0]);
            chk("out32_0", out32[0], m_out[0][0]);
            chk("out32_1", out32[1], m_out[0][1]);
            chk("cnt32", cnt32, m_cnt[0]);
            chk("ovf32", ovf32, m_ovf[0]);
            chk("ready22", rdy22, (!m_valid[1] || out_ready_s) ? 1 : 0);
            chk("valid22", val22, m_valid[1]);
            chk("out22_0", out22[0], m_out[1][0]);
            chk("out22_1", out22[1], m_out[1][1]);
            chk("cnt22", cnt22, m_cnt[1]);
            chk("ovf22", ovf22, m_ovf[1]);
        end
    end

    initial begin
        in_s[0] = 21'sd0;
        in_s[1] = 21'sd0;
        model_reset();
        run = 1'b1;
        do_reset();

        // Three-beat group
        cycle(1'b1, 1'b0, 5, -1, 1'b1);
        cycle(1'b1, 1'b0, -3, -1, 1'b1);
        cycle(1'b1, 1'b1, 10, -1, 1'b1);
        chk("g3_valid", val32, 1);
        chk("g3_out0", out32[0], 12);
        chk("g3_out1", out32[1], -3);
        chk("g3_cnt", cnt32, 3);
        chk("g3_ovf", ovf32, 0);
        chk("g3_model0", m_out[0][0], 12);
        chk("g3_model1", m_out[0][1], -3);

        // Backpressure: result held, offered beat stalls
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, 1'b1, 9, -9, 1'b0);
            chk("bp_ready", rdy32, 0);
            chk("bp_out0", out32[0], 12);
            chk("bp_cnt", cnt32, 3);
        end
        // Pop and last beat together: pending beat taken, no bubble
        cycle(1'b1, 1'b1, 9, -9, 1'b1);
        chk("pl_valid", val32, 1);
        chk("pl_out0", out32[0], 9);
        chk("pl_out1", out32[1], -9);
        chk("pl_cnt", cnt32, 1);

        // Back-to-back single-beat groups
        cycle(1'b1, 1'b1, 7, -7, 1'b1);
        chk("s1_out0", out32[0], 7);
        chk("s1_out1", out32[1], -7);
        chk("s1_cnt", cnt32, 1);
        cycle(1'b1, 1'b1, -2, 4, 1'b1);
        chk("s2_out0", out32[0], -2);
        chk("s2_out1", out32[1], 4);
        chk("s2_valid", val32, 1);
        cycle(1'b1, 1'b1, 100, 0, 1'b1);
        chk("s3_out0", out32[0], 100);
        chk("s3_cnt", cnt32, 1);
        cycle(1'b0, 1'b0, 0, 0, 1'b1);
        chk("drain_valid", val32, 0);
        chk("drain_hold", out32[0], 100);

        // Overflow in the 22-bit instance
        cycle(1'b1, 1'b0, 1048575, 0, 1'b1);
        cycle(1'b1, 1'b0, 1048575, 0, 1'b1);
        cycle(1'b1, 1'b1, 1048575, 0, 1'b1);
        chk("ov_out22", out22[0], -1048579);
        chk("ov_ovf22", ovf22, 1);
        chk("ov_cnt22", cnt22, 3);
        chk("ov_out32", out32[0], 3145725);
        chk("ov_ovf32", ovf32, 0);
        chk("ov_model", m_out[1][0], -1048579);
        cycle(1'b1, 1'b1, 1, 1, 1'b1);
        chk("clean_ovf22", ovf22, 0);
        chk("clean_out22", out22[0], 1);

        // Reset mid-group, then a group starting from zero
        cycle(1'b1, 1'b0, 50, 50, 1'b1);
        cycle(1'b1, 1'b0, 60, 60, 1'b1);
        do_reset();
        cycle(1'b1, 1'b1, 1, 2, 1'b1);
        chk("post_rst_out0", out32[0], 1);
        chk("post_rst_out1", out32[1], 2);
        chk("post_rst_cnt", cnt32, 1);

        // Reset with a result pending
        cycle(1'b1, 1'b1, 3, 3, 1'b0);
        cycle(1'b0, 1'b0, 0, 0, 1'b0);
        chk("pend_valid", val32, 1);
        do_reset();
        cycle(1'b0, 1'b0, 0, 0, 1'b0);

        run = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
